// File: rtl/decode_stage.sv
// RV64 decode stage: combinational field/immediate decode of the fetched word,
// buffered in a main register plus one skid entry so in_ready stays registered.
module decode_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_insn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7_5,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rd_we,
  output logic            out_illegal
);

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_LOAD_FP   = 5'b00001;
  localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_STORE_FP  = 5'b01001;
  localparam logic [4:0] OPC_AMO       = 5'b01011;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_MADD      = 5'b10000;
  localparam logic [4:0] OPC_MSUB      = 5'b10001;
  localparam logic [4:0] OPC_NMSUB     = 5'b10010;
  localparam logic [4:0] OPC_NMADD     = 5'b10011;
  localparam logic [4:0] OPC_OP_FP     = 5'b10100;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            rd_we;
    logic            illegal;
  } decoded_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;

  buf_state_t state, next_state;
  decoded_t   dec, main_q, skid_q;
  logic       in_fire, out_fire;
  logic       load_main, main_from_skid, load_skid;
  logic       opc_known, wr_class;

  always_comb begin
    dec          = '0;
    opc_known    = 1'b0;
    wr_class     = 1'b0;
    dec.pc       = in_pc;
    dec.opcode   = in_insn[6:2];
    dec.funct3   = in_insn[14:12];
    dec.funct7_5 = in_insn[30];
    dec.rd       = in_insn[11:7];
    dec.rs1      = in_insn[19:15];
    dec.rs2      = in_insn[24:20];
    unique case (in_insn[6:2])
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
        opc_known = 1'b1;
        wr_class  = 1'b1;
        dec.imm   = {{(XLEN-12){in_insn[31]}}, in_insn[31:20]};
      end
      OPC_LOAD_FP, OPC_MISC_MEM: begin
        opc_known = 1'b1;
        dec.imm   = {{(XLEN-12){in_insn[31]}}, in_insn[31:20]};
      end
      OPC_SYSTEM: begin
        opc_known = 1'b1;
        wr_class  = (in_insn[14:12] != 3'b000);
        dec.imm   = {{(XLEN-12){in_insn[31]}}, in_insn[31:20]};
      end
      OPC_STORE, OPC_STORE_FP: begin
        opc_known = 1'b1;
        dec.imm   = {{(XLEN-12){in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
      end
      OPC_BRANCH: begin
        opc_known = 1'b1;
        dec.imm   = {{(XLEN-13){in_insn[31]}}, in_insn[31], in_insn[7],
                     in_insn[30:25], in_insn[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        opc_known = 1'b1;
        wr_class  = 1'b1;
        dec.imm   = {{(XLEN-32){in_insn[31]}}, in_insn[31:12], 12'b0};
      end
      OPC_JAL: begin
        opc_known = 1'b1;
        wr_class  = 1'b1;
        dec.imm   = {{(XLEN-21){in_insn[31]}}, in_insn[31], in_insn[19:12],
                     in_insn[20], in_insn[30:21], 1'b0};
      end
      OPC_OP, OPC_OP_32, OPC_AMO: begin
        opc_known = 1'b1;
        wr_class  = 1'b1;
      end
      OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD, OPC_OP_FP: begin
        opc_known = 1'b1;
      end
      default: begin
        opc_known = 1'b0;
      end
    endcase
    dec.illegal = (in_insn[1:0] != 2'b11) || !opc_known
               || ((in_insn[6:2] == OPC_BRANCH) && (in_insn[14:13] == 2'b01))
               || ((in_insn[6:2] == OPC_JALR) && (in_insn[14:12] != 3'b000));
    dec.rd_we   = wr_class && (in_insn[11:7] != 5'd0) && !dec.illegal;
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= next_state;
  end

  // Flush overrides everything; in FULL no accept can occur since in_ready is low.
  always_comb begin
    next_state = state;
    unique case (state)
      EMPTY: if (in_fire) next_state = ONE;
      ONE: begin
        if (in_fire && !out_fire)      next_state = FULL;
        else if (!in_fire && out_fire) next_state = EMPTY;
      end
      FULL:  if (out_fire) next_state = ONE;
      default: next_state = EMPTY;
    endcase
    if (flush) next_state = EMPTY;
  end

  always_comb begin
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      unique case (state)
        EMPTY: load_main = in_fire;
        ONE: begin
          load_main = in_fire && out_fire;
          load_skid = in_fire && !out_fire;
        end
        FULL: begin
          load_main      = out_fire;
          main_from_skid = out_fire;
        end
        default: load_main = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : dec;
      if (load_skid) skid_q <= dec;
    end
  end

  assign out_pc       = main_q.pc;
  assign out_opcode   = main_q.opcode;
  assign out_funct3   = main_q.funct3;
  assign out_funct7_5 = main_q.funct7_5;
  assign out_rd       = main_q.rd;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_imm      = main_q.imm;
  assign out_rd_we    = main_q.rd_we;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field/immediate decode, illegal detection,
// skid backpressure ordering, flush and asynchronous reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_insn;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [4:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7_5;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [63:0] out_imm;
  logic        out_rd_we;
  logic        out_illegal;

  int tests_run = 0;
  int tests_failed = 0;

  decode_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_insn(in_insn),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7_5(out_funct7_5),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for exactly one edge with out_ready held high.
  task automatic apply_stimulus(input logic [31:0] insn, input logic [63:0] pc);
    in_insn  = insn;
    in_pc    = pc;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_insn = '0;
    #12;
    check_output("reset out_valid", {63'd0, out_valid}, 64'd0);
    check_output("reset in_ready", {63'd0, in_ready}, 64'd1);
    check_output("reset out_pc", out_pc, 64'd0);
    check_output("reset out_imm", out_imm, 64'd0);
    rst = 1'b0;
    step();

    apply_stimulus(32'hFFF00093, 64'h1000);
    check_output("addi valid", {63'd0, out_valid}, 64'd1);
    check_output("addi opcode", {59'd0, out_opcode}, 64'h04);
    check_output("addi rd", {59'd0, out_rd}, 64'd1);
    check_output("addi rs1", {59'd0, out_rs1}, 64'd0);
    check_output("addi imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check_output("addi rd_we", {63'd0, out_rd_we}, 64'd1);
    check_output("addi illegal", {63'd0, out_illegal}, 64'd0);
    check_output("addi pc", out_pc, 64'h1000);

    apply_stimulus(32'hFE000EE3, 64'h1004);
    check_output("beq opcode", {59'd0, out_opcode}, 64'h18);
    check_output("beq imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check_output("beq rd_we", {63'd0, out_rd_we}, 64'd0);

    apply_stimulus(32'h123452B7, 64'h1008);
    check_output("lui imm", out_imm, 64'h0000_0000_1234_5000);
    check_output("lui rd", {59'd0, out_rd}, 64'd5);
    check_output("lui rd_we", {63'd0, out_rd_we}, 64'd1);

    apply_stimulus(32'hFE512C23, 64'h100C);
    check_output("sw imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    check_output("sw rs1", {59'd0, out_rs1}, 64'd2);
    check_output("sw rs2", {59'd0, out_rs2}, 64'd5);
    check_output("sw funct3", {61'd0, out_funct3}, 64'd2);
    check_output("sw rd_we", {63'd0, out_rd_we}, 64'd0);

    apply_stimulus(32'h001000EF, 64'h1010);
    check_output("jal imm", out_imm, 64'h800);
    check_output("jal rd_we", {63'd0, out_rd_we}, 64'd1);

    apply_stimulus(32'h402081B3, 64'h1014);
    check_output("sub funct7_5", {63'd0, out_funct7_5}, 64'd1);
    check_output("sub opcode", {59'd0, out_opcode}, 64'h0C);
    check_output("sub imm", out_imm, 64'd0);
    check_output("sub rd_we", {63'd0, out_rd_we}, 64'd1);

    apply_stimulus(32'h000011F3, 64'h1018);
    check_output("csrrw rd_we", {63'd0, out_rd_we}, 64'd1);
    apply_stimulus(32'h00000073, 64'h101C);
    check_output("ecall rd_we", {63'd0, out_rd_we}, 64'd0);

    apply_stimulus(32'h00000000, 64'h1020);
    check_output("zero illegal", {63'd0, out_illegal}, 64'd1);
    check_output("zero rd_we", {63'd0, out_rd_we}, 64'd0);
    apply_stimulus(32'h0000007F, 64'h1024);
    check_output("opc11111 illegal", {63'd0, out_illegal}, 64'd1);
    apply_stimulus(32'h00002063, 64'h1028);
    check_output("br f3=010 illegal", {63'd0, out_illegal}, 64'd1);
    apply_stimulus(32'h00001067, 64'h102C);
    check_output("jalr f3=001 illegal", {63'd0, out_illegal}, 64'd1);
    apply_stimulus(32'h00000013, 64'h1030);
    check_output("nop illegal", {63'd0, out_illegal}, 64'd0);
    check_output("nop rd_we", {63'd0, out_rd_we}, 64'd0);
    step();
    check_output("drain out_valid", {63'd0, out_valid}, 64'd0);

    // Backpressure: A, B, C with out_ready low.
    out_ready = 1'b0;
    in_valid = 1'b1; in_insn = 32'h00100093; in_pc = 64'h2000;
    step();
    check_output("bp A in_ready", {63'd0, in_ready}, 64'd1);
    check_output("bp A out_pc", out_pc, 64'h2000);
    in_insn = 32'h00200113; in_pc = 64'h2004;
    step();
    check_output("bp B in_ready", {63'd0, in_ready}, 64'd0);
    check_output("bp B out_pc", out_pc, 64'h2000);
    in_insn = 32'h00300193; in_pc = 64'h2008;
    step();
    check_output("bp C held in_ready", {63'd0, in_ready}, 64'd0);
    check_output("bp stable out_pc", out_pc, 64'h2000);
    check_output("bp stable rd", {59'd0, out_rd}, 64'd1);
    out_ready = 1'b1;
    step();
    check_output("bp drain B pc", out_pc, 64'h2004);
    check_output("bp drain B rd", {59'd0, out_rd}, 64'd2);
    step();
    in_valid = 1'b0;
    check_output("bp drain C pc", out_pc, 64'h2008);
    check_output("bp drain C rd", {59'd0, out_rd}, 64'd3);
    step();
    check_output("bp empty", {63'd0, out_valid}, 64'd0);

    // Flush from FULL with a concurrent input.
    out_ready = 1'b0;
    in_valid = 1'b1; in_insn = 32'h00100093; in_pc = 64'h3000;
    step();
    in_pc = 64'h3004;
    step();
    flush = 1'b1; in_pc = 64'h3008;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_output("flush out_valid", {63'd0, out_valid}, 64'd0);
    check_output("flush in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_pc = 64'h300C;
    step();
    in_valid = 1'b0;
    check_output("post-flush accept pc", out_pc, 64'h300C);
    out_ready = 1'b1;
    step();
    check_output("flushed entry gone", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h4000;
    step();
    in_pc = 64'h4004;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_output("async rst out_valid", {63'd0, out_valid}, 64'd0);
    check_output("async rst in_ready", {63'd0, in_ready}, 64'd1);
    check_output("async rst out_pc", out_pc, 64'd0);
    check_output("async rst out_imm", out_imm, 64'd0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(32'h00500293, 64'h5000);
    check_output("post-rst valid", {63'd0, out_valid}, 64'd1);
    check_output("post-rst pc", out_pc, 64'h5000);
    check_output("post-rst rd", {59'd0, out_rd}, 64'd5);
    step();
    check_output("post-rst drain", {63'd0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
